// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle control sequencer for the 8-bit accumulator CPU.
// It owns the program counter, fetches instruction bytes from program ROM
// over a req/ack handshake, decodes them and drives one-cycle datapath
// write strobes.
//
// Optional feature macro: SEQ_SINGLE_STEP_EN. When it is defined, the step
// input exists. Every fetch that follows an EXEC then waits for step before
// it raises rom_req.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   rom_req/rom_addr    fetch request and address (= PC)
//   rom_ack/rom_data    ROM data valid and fetched byte
//   instr, imm          latched instruction and immediate bytes
//   carry_in            datapath carry flag (conditional jumps)
//   jump_target         jump destination from the datapath
//   w_acc..w_carry      datapath write strobes, high only in EXEC
//   halted              high while halted (exit only by reset)
//   step                single-step advance (SEQ_SINGLE_STEP_EN only)
module cpu_sequencer #(
  parameter int unsigned            PC_W     = 16,
  parameter logic [PC_W-1:0]        RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            rom_req,
  output logic [PC_W-1:0] rom_addr,
  input  logic            rom_ack,
  input  logic [7:0]      rom_data,
  output logic [7:0]      instr,
  output logic [7:0]      imm,
  input  logic            carry_in,
  input  logic [PC_W-1:0] jump_target,
  output logic            w_acc,
  output logic            w_dx,
  output logic            w_dy,
  output logic            w_sp,
  output logic            w_ioout,
  output logic            w_carry,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic            step,
`endif
  output logic            halted
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_FETCH2 = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      instr_q, instr_d;
  logic [7:0]      imm_q, imm_d;
  logic            fetch_go;   // FETCH may raise rom_req this cycle
  logic            jmp_taken;

`ifdef SEQ_SINGLE_STEP_EN
  // Set on the EXEC->FETCH edge and cleared by step. Reset leaves it clear,
  // so the first fetch after reset does not wait for step.
  logic step_wait_q, step_wait_d;
  assign fetch_go = !step_wait_q || step;
`else
  assign fetch_go = 1'b1;
`endif

  // A JMP byte of 8'hFF is HALT and never reaches EXEC. The check is kept
  // here anyway so that this decode stays correct on its own.
  assign jmp_taken = (instr_q[7:6] == 2'b11) && (instr_q != 8'hFF) &&
                     (!instr_q[0] || carry_in);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      instr_q     <= '0;
      imm_q       <= '0;
`ifdef SEQ_SINGLE_STEP_EN
      step_wait_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      imm_q       <= imm_d;
`ifdef SEQ_SINGLE_STEP_EN
      step_wait_q <= step_wait_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    imm_d       = imm_q;
`ifdef SEQ_SINGLE_STEP_EN
    step_wait_d = step_wait_q;
`endif
    unique case (state_q)
      S_FETCH: begin
`ifdef SEQ_SINGLE_STEP_EN
        if (step) step_wait_d = 1'b0;
`endif
        if (fetch_go && rom_ack) begin
          instr_d = rom_data;
          pc_d    = pc_q + 1'b1;  // wraps modulo 2^PC_W
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (instr_q[7:6] == 2'b10) state_d = S_FETCH2;
        else if (instr_q == 8'hFF) state_d = S_HALT;
        else                       state_d = S_EXEC;
      end
      S_FETCH2: begin
        if (rom_ack) begin
          imm_d   = rom_data;
          pc_d    = pc_q + 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (jmp_taken) pc_d = jump_target;
        state_d = S_FETCH;
`ifdef SEQ_SINGLE_STEP_EN
        step_wait_d = 1'b1;
`endif
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Output decode
  always_comb begin
    rom_req = 1'b0;
    w_acc   = 1'b0;
    w_dx    = 1'b0;
    w_dy    = 1'b0;
    w_sp    = 1'b0;
    w_ioout = 1'b0;
    w_carry = 1'b0;
    halted  = 1'b0;
    unique case (state_q)
      S_FETCH:  rom_req = fetch_go;
      S_FETCH2: rom_req = 1'b1;
      S_HALT:   halted  = 1'b1;
      S_EXEC: begin
        unique case (instr_q[7:6])
          2'b00: begin
            w_acc   = 1'b1;
            w_carry = 1'b1;
          end
          2'b01: begin
            // Destinations 5-7 are NOPs, so no strobe is raised for them.
            unique case (instr_q[2:0])
              3'd0:    w_acc   = 1'b1;
              3'd1:    w_dx    = 1'b1;
              3'd2:    w_dy    = 1'b1;
              3'd3:    w_sp    = 1'b1;
              3'd4:    w_ioout = 1'b1;
              default: ;
            endcase
          end
          2'b10:   w_acc = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign rom_addr = pc_q;
  assign instr    = instr_q;
  assign imm      = imm_q;

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control sequencer for the 8-bit accumulator CPU datapath: acc, dx, dy, sp, carry and ioout. It owns the program counter and fetches instruction bytes from program ROM over a req/ack handshake. It decodes each instruction and drives the datapath's one-cycle write strobes (w_acc … w_carry), so the datapath needs no control logic of its own.

## Interface
- PC_W, 16, program counter / ROM address width
- RESET_PC, 0, PC value loaded on reset
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- rom_req  output  1  fetch request; high in FETCH and FETCH2
- rom_addr  output  PC_W  fetch address (= PC)
- rom_ack  input  1  ROM data valid this cycle; ignored when rom_req low
- rom_data  input  8  fetched byte
- instr  output  8  latched current instruction byte
- imm  output  8  latched immediate byte (IMM class)
- carry_in  input  1  current datapath carry flag
- jump_target  input  PC_W  jump destination from datapath
- w_acc, w_dx, w_dy, w_sp, w_ioout, w_carry  output  1 each  datapath write strobes
- halted  output  1  high while in HALT
- step  input  1  single-step advance (only when SEQ_SINGLE_STEP_EN defined)

## Operation
- Instruction classes by instr[7:6]:
  - 00 ALU: EXEC asserts w_acc and w_carry.
  - 01 MOV: dest instr[2:0]: 0 acc, 1 dx, 2 dy, 3 sp, 4 ioout; 5–7 assert no strobe (NOP).
  - 10 IMM: two bytes; second byte latched into imm; EXEC asserts w_acc.
  - 11 JMP: 8'hFF = HALT. Otherwise the jump is taken if instr[0]==0 (unconditional) or carry_in==1, and EXEC loads PC ← jump_target. If not taken, PC is unchanged by EXEC.
- States (one-hot or binary, implementer's choice):
  - FETCH: rom_req high. On rom_ack: instr ← rom_data, PC ← PC+1, go to DECODE.
  - DECODE: IMM → FETCH2; instr==8'hFF → HALT; else → EXEC.
  - FETCH2: rom_req high. On rom_ack: imm ← rom_data, PC ← PC+1, go to EXEC.
  - EXEC: strobes asserted (combinational decode of state+instr), PC load if jump taken, then → FETCH.
  - HALT: no strobes, rom_req low, halted high; exit only by reset.
- Handshake: rom_req and rom_addr remain stable until the rom_ack cycle. The ROM may assert ack in the same cycle req rises (zero wait).
- PC arithmetic: modulo 2^PC_W; increment from all-ones wraps to 0.
- At most one MOV strobe per instruction. Strobes are never high outside EXEC.

## Timing
- Reset (async, immediate): state FETCH, PC=RESET_PC, instr=0, imm=0. All outputs then read: rom_req=1 (decode of FETCH), rom_addr=RESET_PC, all w_*=0, halted=0.
- Zero-wait ROM: 3 cycles per 1-byte instruction (FETCH, DECODE, EXEC); 4 cycles for IMM.
- Each cycle with rom_ack low in FETCH/FETCH2 adds one cycle.
- Strobes are high for exactly one cycle. The datapath captures on the rising edge ending EXEC.
- A jump-taken EXEC places jump_target on rom_addr in the next (FETCH) cycle.
- Reset mid-transaction: the pending fetch is abandoned and any strobe drops immediately. A late rom_ack arriving after reset is treated as acking the RESET_PC fetch; the ROM must drop ack with req.

## Configuration
- SEQ_SINGLE_STEP_EN defined: the step port exists. On entering FETCH from EXEC (not from reset), rom_req stays low until a cycle with step==1; that cycle raises rom_req. The first fetch after reset is free.
- Undefined: no step port; free-running.

## Test plan
- Reset release, ROM byte 8'h41 (MOV→dx) at 0, zero-wait → rom_addr 0, w_dx high only in cycle 3, rom_addr=1 in cycle 4.
- IMM 8'h80,8'h5A at 0/1 → imm=8'h5A, w_acc in cycle 4, next fetch address 2.
- rom_ack delayed 3 cycles on first fetch → rom_req/rom_addr stable throughout, instruction completes in 6 cycles.
- JMP 8'hC1 with carry_in=0 → no PC load, next addr 1; with carry_in=1, jump_target=16'h1234 → next addr 16'h1234.
- PC=16'hFFFF, 1-byte NOP 8'h47 → next fetch addr 16'h0000. Then 8'hFF → halted=1, rom_req=0 indefinitely.
- rst_n pulsed low during EXEC of ALU op → w_acc/w_carry drop immediately, rom_addr=RESET_PC.
